input_setup: RTL
================

Name: input_setup

Overview:
- Downstream neighbour of the unified buffer.
- Captures one 2x2 activation tile (four words presented on the unified buffer's read outputs) and streams it into the 2x2 systolic array's left edge with diagonal skew: row 1 lags row 0 by one cycle.
- A valid/ready handshake lets the controller issue back-to-back tiles with no bubble.
- Asserts a done pulse on the last feed cycle of each tile.

Parameters:
- DATA_WIDTH, 32, width of each activation word and each array input.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_in  input  1  tile words on ub_in_* are valid this cycle; controller drives it one cycle after pulsing the unified buffer's load_input.
- ub_in_00  input  DATA_WIDTH  tile element row 0, col 0.
- ub_in_01  input  DATA_WIDTH  tile element row 0, col 1.
- ub_in_10  input  DATA_WIDTH  tile element row 1, col 0.
- ub_in_11  input  DATA_WIDTH  tile element row 1, col 1.
- ready  output  1  combinational; block accepts a tile this cycle.
- a_row0  output  DATA_WIDTH  registered activation into systolic row 0.
- a_row1  output  DATA_WIDTH  registered activation into systolic row 1.
- a_valid0  output  1  a_row0 carries data.
- a_valid1  output  1  a_row1 carries data.
- busy  output  1  registered; high in any non-IDLE state.
- done  output  1  registered; one-cycle pulse on the final feed cycle of a tile.

Behaviour:
- Reset (async, immediate): state=IDLE; all four tile registers=0; a_row0=a_row1=0; a_valid0=a_valid1=0; busy=0; done=0. Reset mid-stream aborts the tile; no partial output follows deassertion.
- FSM states: IDLE, S0, S1, S2. The state register reflects what is currently on the outputs.
- ready = (state==IDLE) || (state==S2).
- Capture rule: valid_in && ready at a rising edge latches all four ub_in_* into the tile registers and sets state to S0. valid_in && !ready is ignored; nothing is captured and upstream must re-present the tile.
- Output values per state (set on the edge entering the state):
  - S0: a_row0=t00, v0=1; a_row1=0, v1=0; done=0.
  - S1: a_row0=t01, v0=1; a_row1=t10, v1=1; done=0.
  - S2: a_row0=0, v0=0; a_row1=t11, v1=1; done=1.
  - IDLE: both rows 0, both valids 0, done=0.
- Transitions:
  - IDLE→S0 on capture, else stay IDLE.
  - S0→S1 unconditionally.
  - S1→S2 unconditionally.
  - S2→S0 on capture, else IDLE.
- Back-to-back tiles: a capture during S2 overwrites the tile registers at the same edge S2 is exited. t11 for the old tile is already on a_row1 and is not disturbed. The new tile's t00 appears at the next cycle, giving zero bubble.
- Latency: a tile captured at edge N puts t00 on a_row0 after edge N. t11 appears on a_row1 after edge N+2, concurrent with done. A tile occupies 3 cycles.
- Data is passed unmodified. There is no arithmetic, and the full DATA_WIDTH is preserved.
- Idle-zero rule: an invalid output lane always drives 0, never stale data.
- busy is high in S0, S1 and S2.

Test Plan:
- Reset then idle: hold valid_in=0 for 5 cycles -> ready=1, busy=0, done=0, rows 0, valids 0 throughout.
- Single tile: valid_in=1 one cycle with words 11,12,21,22 -> next 3 cycles (a_row0,a_row1,v0,v1) = (11,0,1,0), (12,21,1,1), (0,22,0,1); done=1 only on the 3rd; then IDLE with zeros.
- Back-to-back: tile A {1,2,3,4}, then tile B {5,6,7,8} offered in A's S2 cycle -> a_row0 sequence 1,2,0,5,6,0 and a_row1 sequence 0,3,4,0,7,8; done pulses twice, 3 cycles apart; busy stays high for 6 cycles.
- Not-ready drop: offer tile {9,9,9,9} during S0 or S1 of tile {1,2,3,4} -> ignored; outputs match a single-tile stream of {1,2,3,4} followed by IDLE.
- Async reset mid-stream: assert reset during S1 -> outputs, valids and busy go to 0 immediately without waiting for a clock edge; after release, IDLE and ready=1.
- Width check: DATA_WIDTH=32 with words 0xFFFFFFFF, 0x80000000, 0x7FFFFFFF, 0x00000001 -> values reproduced bit-exact on the array outputs.

Source files
------------

// File: rtl/input_setup.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : input_setup                                                  |
// | Description : Captures a 2x2 activation tile and feeds it diagonally       |
// |               skewed into the left edge of a 2x2 systolic array.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module input_setup #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] ub_in_00,
  input  logic [DATA_WIDTH-1:0] ub_in_01,
  input  logic [DATA_WIDTH-1:0] ub_in_10,
  input  logic [DATA_WIDTH-1:0] ub_in_11,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] a_row0,
  output logic [DATA_WIDTH-1:0] a_row1,
  output logic                  a_valid0,
  output logic                  a_valid1,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S0   = 2'd1,
    S1   = 2'd2,
    S2   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_t00, r_t01, r_t10, r_t11;
  logic [DATA_WIDTH-1:0] r_a_row0, r_a_row1;
  logic                  r_a_valid0, r_a_valid1, r_busy, r_done;
  logic [DATA_WIDTH-1:0] w_row0_nxt, w_row1_nxt;
  logic                  w_valid0_nxt, w_valid1_nxt, w_done_nxt;
  logic                  w_capture;

  assign ready     = (r_state == IDLE) || (r_state == S2);
  assign w_capture = valid_in && ready;

  always_comb begin
    w_state_nxt  = IDLE;
    w_row0_nxt   = '0;
    w_row1_nxt   = '0;
    w_valid0_nxt = 1'b0;
    w_valid1_nxt = 1'b0;
    w_done_nxt   = 1'b0;

    case (r_state)
      IDLE:    w_state_nxt = w_capture ? S0 : IDLE;
      S0:      w_state_nxt = S1;
      S1:      w_state_nxt = S2;
      S2:      w_state_nxt = w_capture ? S0 : IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // S0 is only entered on a capture, so t00 comes straight from the bus.
    case (w_state_nxt)
      S0: begin
        w_row0_nxt   = ub_in_00;
        w_valid0_nxt = 1'b1;
      end
      S1: begin
        w_row0_nxt   = r_t01;
        w_row1_nxt   = r_t10;
        w_valid0_nxt = 1'b1;
        w_valid1_nxt = 1'b1;
      end
      S2: begin
        w_row1_nxt   = r_t11;
        w_valid1_nxt = 1'b1;
        w_done_nxt   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_t00      <= '0;
      r_t01      <= '0;
      r_t10      <= '0;
      r_t11      <= '0;
      r_a_row0   <= '0;
      r_a_row1   <= '0;
      r_a_valid0 <= 1'b0;
      r_a_valid1 <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_a_row0   <= w_row0_nxt;
      r_a_row1   <= w_row1_nxt;
      r_a_valid0 <= w_valid0_nxt;
      r_a_valid1 <= w_valid1_nxt;
      r_busy     <= (w_state_nxt != IDLE);
      r_done     <= w_done_nxt;
      if (w_capture) begin
        r_t00 <= ub_in_00;
        r_t01 <= ub_in_01;
        r_t10 <= ub_in_10;
        r_t11 <= ub_in_11;
      end
    end
  end

  assign a_row0   = r_a_row0;
  assign a_row1   = r_a_row1;
  assign a_valid0 = r_a_valid0;
  assign a_valid1 = r_a_valid1;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
`default_nettype wire
